// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and default widths for the register-file dump reader.
package regfile_dump_reader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int unsigned REGFILE_DATA_WIDTH = 32;
   localparam int unsigned REGFILE_ADDR_WIDTH = 5;

endpackage

// File: rtl/regfile_dump_reader_reg.sv
// Plain N-bit register with load enable and asynchronous active-high clear.
module reg_word
   import regfile_dump_reader_pkg::*;
#(
   parameter int unsigned WIDTH = REGFILE_DATA_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Hold value unless enabled; clear wins at any time.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)     q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a contiguous register range and streams each word out over valid/ready.
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = REGFILE_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH,
   parameter int unsigned NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam int unsigned SUM_W = ADDR_WIDTH + 2;

   state_t                state, state_d;
   logic [ADDR_WIDTH-1:0] cur, cur_d, rd_addr_c;
   logic [CNT_W-1:0]      rem, rem_d;
   logic [SUM_W-1:0]      range_end_c;
   logic                  range_bad_c, hs_c;
   logic                  accept_c, reject_c, cap_c, adv_c, valid_d;

   assign range_end_c = SUM_W'(base) + SUM_W'(count);
   assign range_bad_c = (count == '0) || (range_end_c > SUM_W'(NUM_REGS));
   assign hs_c        = out_valid & out_ready;
   assign rd_addr     = rd_addr_c;

   // Next state, read address and datapath enables.
   always_comb begin
      state_d   = state;
      rd_addr_c = '0;
      accept_c  = 1'b0;
      reject_c  = 1'b0;
      cap_c     = 1'b0;
      adv_c     = 1'b0;
      valid_d   = out_valid;
      case (state)
         IDLE: begin
            if (start) begin
               if (range_bad_c) begin
                  reject_c = 1'b1;
               end else begin
                  accept_c = 1'b1;
                  state_d  = LOAD;
               end
            end
         end
         LOAD: begin
            rd_addr_c = cur;
            cap_c     = 1'b1;
            valid_d   = 1'b1;
            state_d   = SEND;
         end
         SEND: begin
            // Next word is pre-presented so a handshake can capture it at once.
            rd_addr_c = cur + ADDR_WIDTH'(1);
            if (hs_c) begin
               if (rem > CNT_W'(1)) begin
                  cap_c = 1'b1;
                  adv_c = 1'b1;
               end else begin
                  valid_d = 1'b0;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cur_d = accept_c ? base  : cur + ADDR_WIDTH'(1);
   assign rem_d = accept_c ? count : rem - CNT_W'(1);

   // State and registered status outputs.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_d;
         out_valid <= valid_d;
         busy      <= (state_d != IDLE);
         done      <= (state_d == DONE);
         err       <= reject_c;
      end
   end

   reg_word #(.WIDTH(DATA_WIDTH)) u_out_data (
      .clk(clk), .clr(clr), .en(cap_c), .d(rd_data), .q(out_data)
   );

   reg_word #(.WIDTH(ADDR_WIDTH)) u_out_addr (
      .clk(clk), .clr(clr), .en(cap_c), .d(rd_addr_c), .q(out_addr)
   );

   reg_word #(.WIDTH(ADDR_WIDTH)) u_cur (
      .clk(clk), .clr(clr), .en(accept_c | adv_c), .d(cur_d), .q(cur)
   );

   reg_word #(.WIDTH(CNT_W)) u_rem (
      .clk(clk), .clr(clr), .en(accept_c | adv_c), .d(rem_d), .q(rem)
   );

endmodule
